// File: rtl/button_updown_counter_if.sv
// Board-side bundle for the push-button up/down counter: raw buttons and load in,
// registered count and status out.
interface button_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             btn_up;
  logic             btn_dn;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             wrapped;
  logic             at_min;
  logic             at_max;
  logic             up_held;
  logic             dn_held;

  modport master (
    output btn_up, btn_dn, load, load_value,
    input  count, wrapped, at_min, at_max, up_held, dn_held
  );

  modport slave (
    input  btn_up, btn_dn, load, load_value,
    output count, wrapped, at_min, at_max, up_held, dn_held
  );
endinterface

// File: rtl/button_updown_counter.sv
// Push-button up/down counter: each active-low button is synchronised, debounced and
// auto-repeated into step strobes that drive a range-limited wrapping/saturating count.
module button_updown_channel #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_RATE    = 2500000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_n,
  output logic held,
  output logic step
);
  localparam int DB_W   = (DEBOUNCE_LIMIT < 1) ? 1 : $clog2(DEBOUNCE_LIMIT + 1);
  localparam int TM_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TM_W   = (TM_MAX < 1) ? 1 : $clog2(TM_MAX + 1);

  localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_LIMIT);
  localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
  localparam logic [TM_W-1:0] DELAY_V  = TM_W'(REPEAT_DELAY);
  localparam logic [TM_W-1:0] RATE_V   = TM_W'(REPEAT_RATE);
  localparam logic [TM_W-1:0] TM_ONE   = TM_W'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [1:0]      sync_q, sync_d;
  logic            pressed_q, pressed_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]      state_q, state_d;
  logic [TM_W-1:0] timer_q, timer_d, timer_inc;

  // The counter only runs while the synced level disagrees with the accepted level.
  always_comb begin
    sync_d    = {sync_q[0], btn_n};
    pressed_d = pressed_q;
    db_cnt_d  = '0;
    if ((~sync_q[1]) != pressed_q) begin
      if (db_cnt_q + DB_ONE == DB_LIMIT) begin
        pressed_d = ~sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    step      = 1'b0;
    timer_inc = timer_q + TM_ONE;
    case (state_q)
      ST_IDLE: begin
        if (pressed_q) begin
          step    = 1'b1;
          timer_d = '0;
          state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (!pressed_q) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (REPEAT_DELAY != 0) begin
          if (timer_inc == DELAY_V) begin
            step    = 1'b1;
            timer_d = '0;
            state_d = ST_REPEAT;
          end else begin
            timer_d = timer_inc;
          end
        end
      end
      ST_REPEAT: begin
        if (!pressed_q) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_inc == RATE_V) begin
          step    = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= 2'b11;
      pressed_q <= 1'b0;
      db_cnt_q  <= '0;
      state_q   <= ST_IDLE;
      timer_q   <= '0;
    end else begin
      sync_q    <= sync_d;
      pressed_q <= pressed_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
    end
  end

  assign held = pressed_q;
endmodule

module button_updown_counter #(
  parameter int WIDTH          = 4,
  parameter int CNT_MIN        = 0,
  parameter int CNT_MAX        = 2**WIDTH - 1,
  parameter int WRAP           = 1,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_RATE    = 2500000
) (
  input logic                       clock,
  input logic                       reset_n,
  button_updown_counter_if.slave    bus
);
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(CNT_MIN);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(CNT_MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic             up_step, dn_step;
  logic             up_held, dn_held;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic             at_min_q, at_min_d;
  logic             at_max_q, at_max_d;

  button_updown_channel #(
    .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_up (
    .clock   (clock),
    .reset_n (reset_n),
    .btn_n   (bus.btn_up),
    .held    (up_held),
    .step    (up_step)
  );

  button_updown_channel #(
    .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_dn (
    .clock   (clock),
    .reset_n (reset_n),
    .btn_n   (bus.btn_dn),
    .held    (dn_held),
    .step    (dn_step)
  );

  // Load wins over strobes; opposing strobes in one cycle cancel out.
  always_comb begin
    count_d   = count_q;
    wrapped_d = 1'b0;
    if (bus.load) begin
      if (bus.load_value < MIN_V) begin
        count_d = MIN_V;
      end else if (bus.load_value > MAX_V) begin
        count_d = MAX_V;
      end else begin
        count_d = bus.load_value;
      end
    end else if (up_step && !dn_step) begin
      if (count_q == MAX_V) begin
        if (WRAP != 0) begin
          count_d   = MIN_V;
          wrapped_d = 1'b1;
        end
      end else begin
        count_d = count_q + ONE_V;
      end
    end else if (dn_step && !up_step) begin
      if (count_q == MIN_V) begin
        if (WRAP != 0) begin
          count_d   = MAX_V;
          wrapped_d = 1'b1;
        end
      end else begin
        count_d = count_q - ONE_V;
      end
    end
    at_min_d = (count_d == MIN_V);
    at_max_d = (count_d == MAX_V);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= MIN_V;
      wrapped_q <= 1'b0;
      at_min_q  <= 1'b1;
      at_max_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
      at_min_q  <= at_min_d;
      at_max_q  <= at_max_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.wrapped = wrapped_q;
  assign bus.at_min  = at_min_q;
  assign bus.at_max  = at_max_q;
  assign bus.up_held = up_held;
  assign bus.dn_held = dn_held;
endmodule

// File: doc/button_updown_counter.md
# button_updown_counter

Parametrised successor to the board's push-button up/down counter. It synchronises and debounces two active-low buttons, counts one step per clean press, and auto-repeats while a button is held. The count range is configurable, with wrap or saturate at the limits and a synchronous load. It sits between the board button pins and display/LED logic.

## Interface
- WIDTH, 4: count width in bits.
- CNT_MIN, 0: lowest count value; reset value.
- CNT_MAX, 2**WIDTH-1: highest count value; CNT_MIN < CNT_MAX < 2**WIDTH.
- WRAP, 1: 1 = wrap at limits, 0 = saturate.
- DEBOUNCE_LIMIT, 250000: consecutive stable cycles required to accept a level change (10 ms at 25 MHz).
- REPEAT_DELAY, 12500000: hold cycles before the first auto-repeat step; 0 disables auto-repeat.
- REPEAT_RATE, 2500000: cycles between subsequent auto-repeat steps; must be ≥ 1.

Ports:
- clock  in  1  single clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- btn_up  in  1  raw up button, active low, asynchronous to clock.
- btn_dn  in  1  raw down button, active low, asynchronous to clock.
- load  in  1  synchronous load strobe, active high.
- load_value  in  WIDTH  value loaded when load = 1.
- count  out  WIDTH  current count.
- wrapped  out  1  one-cycle pulse when the count wraps (WRAP = 1 only).
- at_min  out  1  count == CNT_MIN.
- at_max  out  1  count == CNT_MAX.
- up_held, dn_held  out  1 each  debounced pressed level, active high.

## Operation
- Per button: a 2-flop synchroniser, then a debouncer, then a repeat FSM. Both channels are identical instances.
- Synchroniser flops reset to 1 (released).
- Debouncer: the counter increments while the synced input ≠ the debounced state. When it reaches DEBOUNCE_LIMIT, the state takes the input and the counter clears. The counter clears whenever the input equals the state, so a glitch shorter than DEBOUNCE_LIMIT cycles never propagates. The counter is $clog2(DEBOUNCE_LIMIT+1) bits wide.
- Repeat FSM states:
  - IDLE: on debounced press, issue a step strobe, clear the timer, go to DELAY.
  - DELAY: the timer counts held cycles. When it reaches REPEAT_DELAY, issue a step, clear the timer, go to REPEAT. If REPEAT_DELAY = 0, stay in DELAY with no repeat.
  - REPEAT: every REPEAT_RATE cycles, issue a step and clear the timer.
  - Any state: debounced release returns to IDLE without a step.
- Count update priority:
  1. load: count ← load_value clamped to [CNT_MIN, CNT_MAX].
  2. Up and down strobes in the same cycle: no change.
  3. Up strobe: count+1.
  4. Down strobe: count−1.
- Limits:
  - Up at CNT_MAX: with WRAP=1, count ← CNT_MIN and wrapped = 1 for one cycle. With WRAP=0, count holds and wrapped stays 0.
  - Down at CNT_MIN: with WRAP=1, count ← CNT_MAX and wrapped = 1. With WRAP=0, count holds.
- A load never asserts wrapped. Strobes coinciding with load are discarded.

## Timing
- Reset values: count = CNT_MIN, wrapped = 0, at_min = 1, at_max = 0, up_held = dn_held = 0. FSMs are in IDLE; all timers and debounce counters are 0.
- A reset asserted mid-hold or mid-debounce aborts immediately (asynchronous). After release, a still-held button needs a full debounce before its first step.
- Press latency: from a raw edge stable at cycle 0, up_held/dn_held rise at cycle 2 + DEBOUNCE_LIMIT, and count changes one cycle later.
- Auto-repeat cadence:
  - The second step lands REPEAT_DELAY cycles after the first.
  - Later steps follow every REPEAT_RATE cycles.
- count, wrapped, at_min and at_max are all registered and change on the same edge.
- load takes effect on the next edge: one-cycle latency.

## Test plan
Parameters for all scenarios: WIDTH=4, CNT_MIN=2, CNT_MAX=9, DEBOUNCE_LIMIT=4, REPEAT_DELAY=10, REPEAT_RATE=3, WRAP=1 unless noted.

- Reset, then a clean btn_up press held 8 cycles and released -> count 2→3 exactly at cycle 7 after the edge; one step only; at_min falls on the same edge.
- btn_up bounce of 0/1 pulses, each ≤ 3 cycles, for 20 cycles, then stable high -> count stays 2; up_held never asserts.
- Hold btn_up from count 7 for 30 cycles past the first step -> steps at +0, +10, +13, +16, …, giving 8, 9, 2 (wrapped pulse), 3, …
- WRAP=0: hold btn_dn at count 2 -> count stays 2, wrapped stays 0, at_min stays 1. Then load=1 with load_value=15 -> count = 9, at_max = 1, no wrapped pulse.
- Both buttons pressed on the same cycle -> no count change; release btn_dn only while btn_up is held -> up repeats continue per cadence.
- Assert reset_n=0 mid-REPEAT at count 6 -> count = 2 immediately (asynchronous). Release reset with btn_up still held -> first step occurs 2+4+1 cycles after release.
